cursor_report_tx: RTL and testbench

Parametrised successor to the fixed two-axis cursor UART transmitter, feeding the serial link at the end of the cursor pipeline (after map and click latching). It accumulates signed per-axis motion deltas between reports and carries any unsent remainder forward. On a send request it emits a framed report (sync, buttons, N axes, XOR checksum) as 8N1 UART. Send requests that arrive while busy are queued one deep, and the rest are counted as drops.

---
 rtl/cursor_pkg.sv | 32 +++
 rtl/cursor_uart_byte_tx.sv | 81 ++++++++
 rtl/cursor_report_tx.sv | 123 ++++++++++++
 tb/tb_cursor_report_tx.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cursor_pkg.sv
// Shared types and arithmetic helpers for the cursor pipeline.
// Used by cursor_report_tx and cursor_map.
package cursor_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_STOP
   } tx_state_t;

   localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

   function automatic int frame_len(input int num_axes, input int delta_w);
      return 3 + num_axes * (delta_w / 8);
   endfunction

   function automatic int clamp_s(input int v, input int w);
      int hi;
      int lo;
      hi = (1 << (w - 1)) - 1;
      lo = -(1 << (w - 1));
      if (v > hi) return hi;
      if (v < lo) return lo;
      return v;
   endfunction

   function automatic int sat_add(input int a, input int b, input int w);
      return clamp_s(a + b, w);
   endfunction

endpackage

// File: rtl/cursor_uart_byte_tx.sv
// 8N1 byte serialiser with valid/ready handshake.
// Ready on the last stop-bit cycle, so bytes chain with no idle gap.
module cursor_uart_byte_tx
   import cursor_pkg::*;
#(
   parameter int CLKS_PER_BIT = 434
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       byte_valid,
   input  logic [7:0] byte_data,
   output logic       byte_ready,
   output logic       tx
);

   localparam int BW = $clog2(CLKS_PER_BIT);
   localparam logic [BW-1:0] LAST = BW'(CLKS_PER_BIT - 1);

   tx_state_t  state;
   logic [BW-1:0] baud;
   logic [2:0] bit_idx;
   logic [7:0] sh;
   logic       bit_end;

   assign bit_end    = (baud == LAST);
   assign byte_ready = (state == ST_IDLE) ||
                       (state == ST_STOP && bit_end);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= ST_IDLE;
         baud    <= '0;
         bit_idx <= '0;
         sh      <= '0;
         tx      <= 1'b1;
      end else begin
         baud <= (bit_end || state == ST_IDLE) ? '0 : baud + BW'(1);
         unique case (state)
            ST_IDLE: begin
               if (byte_valid) begin
                  state <= ST_START;
                  sh    <= byte_data;
                  tx    <= 1'b0;
               end
            end
            ST_START: begin
               if (bit_end) begin
                  state   <= ST_DATA;
                  bit_idx <= '0;
                  tx      <= sh[0];
               end
            end
            ST_DATA: begin
               if (bit_end) begin
                  if (bit_idx == 3'd7) begin
                     state <= ST_STOP;
                     tx    <= 1'b1;
                  end else begin
                     bit_idx <= bit_idx + 3'd1;
                     tx      <= sh[1];
                     sh      <= {1'b0, sh[7:1]};
                  end
               end
            end
            ST_STOP: begin
               if (bit_end) begin
                  if (byte_valid) begin
                     state <= ST_START;
                     sh    <= byte_data;
                     tx    <= 1'b0;
                  end else begin
                     state <= ST_IDLE;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/cursor_report_tx.sv
// Cursor report framer: per-axis saturating accumulators, snapshot on
// send, one-deep request queue, drop counter, 8N1 serial output.
module cursor_report_tx
   import cursor_pkg::*;
#(
   parameter int NUM_AXES     = 2,
   parameter int DELTA_W      = 8,
   parameter int ACC_W        = 12,
   parameter int NUM_BTNS     = 2,
   parameter int CLKS_PER_BIT = 434,
   parameter logic [7:0] SYNC_BYTE = SYNC_DEFAULT
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        in_valid,
   input  logic [NUM_AXES*DELTA_W-1:0] in_delta,
   input  logic [NUM_BTNS-1:0]         buttons,
   input  logic                        send,
   output logic                        tx,
   output logic                        busy,
   output logic                        pending,
   output logic [7:0]                  drop_cnt
);

   localparam int FLEN = frame_len(NUM_AXES, DELTA_W);
   localparam int NB   = DELTA_W / 8;
   localparam int IW   = $clog2(FLEN + 1);

   logic signed [ACC_W-1:0] acc     [NUM_AXES];
   logic signed [ACC_W-1:0] acc_nxt [NUM_AXES];
   logic [7:0]  frame     [FLEN];
   logic [7:0]  frame_nxt [FLEN];
   logic [IW-1:0] idx;
   logic [7:0]  cur_byte;
   logic [7:0]  u_data;
   logic [7:0]  cs;
   logic [DELTA_W-1:0] sb;
   logic        u_ready;
   logic        u_valid;
   logic        more;
   logic        frame_done;
   logic        accept;
   int          a_v;
   int          s_v;
   int          d_v;
   int          b_v;

   assign more       = busy && u_ready && (idx != IW'(FLEN));
   assign frame_done = busy && u_ready && (idx == IW'(FLEN));
   assign accept     = (!busy || frame_done) && (send || pending);
   assign u_valid    = accept || more;
   assign u_data     = accept ? SYNC_BYTE : cur_byte;

   always_comb begin
      cur_byte = '0;
      for (int j = 0; j < FLEN; j++)
         if (idx == IW'(j)) cur_byte = frame[j];
   end

   // Snapshot clamps each axis to the wire range; the rest stays behind.
   always_comb begin
      a_v = 0;
      s_v = 0;
      d_v = 0;
      b_v = 0;
      sb  = '0;
      cs  = '0;
      for (int j = 0; j < FLEN; j++) frame_nxt[j] = '0;
      frame_nxt[0] = SYNC_BYTE;
      frame_nxt[1] = 8'(buttons);
      for (int i = 0; i < NUM_AXES; i++) begin
         a_v = int'(acc[i]);
         s_v = clamp_s(a_v, DELTA_W);
         sb  = DELTA_W'(s_v);
         for (int b = 0; b < NB; b++)
            frame_nxt[2 + i*NB + b] = sb[b*8 +: 8];
         d_v = in_valid ?
               int'(signed'(in_delta[i*DELTA_W +: DELTA_W])) : 0;
         b_v = accept ? a_v - s_v : a_v;
         acc_nxt[i] = ACC_W'(sat_add(b_v, d_v, ACC_W));
      end
      for (int j = 1; j < FLEN - 1; j++) cs = cs ^ frame_nxt[j];
      frame_nxt[FLEN-1] = cs;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy     <= 1'b0;
         pending  <= 1'b0;
         drop_cnt <= '0;
         idx      <= '0;
         for (int i = 0; i < NUM_AXES; i++) acc[i] <= '0;
         for (int j = 0; j < FLEN; j++) frame[j] <= '0;
      end else begin
         for (int i = 0; i < NUM_AXES; i++) acc[i] <= acc_nxt[i];
         if (accept) begin
            for (int j = 0; j < FLEN; j++) frame[j] <= frame_nxt[j];
            busy    <= 1'b1;
            idx     <= IW'(1);
            pending <= pending && send;
         end else begin
            if (frame_done) busy <= 1'b0;
            if (more) idx <= idx + IW'(1);
            if (busy && send) begin
               if (!pending) pending <= 1'b1;
               else if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
            end
         end
      end
   end

   cursor_uart_byte_tx #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_byte_tx (
      .clk       (clk),
      .rst       (rst),
      .byte_valid(u_valid),
      .byte_data (u_data),
      .byte_ready(u_ready),
      .tx        (tx)
   );

endmodule

// File: tb/tb_cursor_report_tx.sv
// Directed bench: UART receivers decode both DUTs into a byte scoreboard.
// Fast baud keeps every frame short.
module tb_cursor_report_tx;
   import cursor_pkg::*;

   localparam int CPB = 16;

   logic clk = 1'b0;
   logic rst = 1'b1;

   logic        in_valid0 = 1'b0;
   logic [15:0] in_delta0 = '0;
   logic [1:0]  buttons0  = '0;
   logic        send0     = 1'b0;
   logic        tx0, busy0, pending0;
   logic [7:0]  drop0;

   logic        in_valid1 = 1'b0;
   logic [47:0] in_delta1 = '0;
   logic [1:0]  buttons1  = '0;
   logic        send1     = 1'b0;
   logic        tx1, busy1, pending1;
   logic [7:0]  drop1;

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;

   logic [7:0] q0[$];
   logic [7:0] q1[$];

   cursor_report_tx #(.CLKS_PER_BIT(CPB)) dut0 (
      .clk(clk), .rst(rst), .in_valid(in_valid0), .in_delta(in_delta0),
      .buttons(buttons0), .send(send0), .tx(tx0), .busy(busy0),
      .pending(pending0), .drop_cnt(drop0)
   );

   cursor_report_tx #(
      .NUM_AXES(3), .DELTA_W(16), .ACC_W(20), .CLKS_PER_BIT(CPB)
   ) dut1 (
      .clk(clk), .rst(rst), .in_valid(in_valid1), .in_delta(in_delta1),
      .buttons(buttons1), .send(send1), .tx(tx1), .busy(busy1),
      .pending(pending1), .drop_cnt(drop1)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // UART receivers, sampling at mid-bit on the falling edge
   logic       rx_act [2] = '{1'b0, 1'b0};
   int         rx_cnt [2] = '{0, 0};
   logic [7:0] rx_sh  [2];
   logic       txw    [2];
   assign txw[0] = tx0;
   assign txw[1] = tx1;

   always @(negedge clk) begin
      for (int c = 0; c < 2; c++) begin
         if (rst) begin
            rx_act[c] = 1'b0;
         end else if (!rx_act[c]) begin
            if (!txw[c]) begin
               rx_act[c] = 1'b1;
               rx_cnt[c] = 0;
            end
         end else begin
            rx_cnt[c]++;
            for (int k = 1; k <= 8; k++)
               if (rx_cnt[c] == k*CPB + CPB/2) rx_sh[c][k-1] = txw[c];
            if (rx_cnt[c] == 9*CPB + CPB/2) begin
               logic [7:0] want;
               rx_act[c] = 1'b0;
               check($sformatf("stop%0d", c), {31'd0, txw[c]}, 32'd1);
               if ((c == 0 ? q0.size() : q1.size()) == 0) begin
                  check($sformatf("extra_byte%0d", c), 32'd1, 32'd0);
               end else begin
                  want = (c == 0) ? q0.pop_front() : q1.pop_front();
                  check($sformatf("rx%0d_byte", c), {24'd0, rx_sh[c]},
                        {24'd0, want});
               end
            end
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic push0(input logic [7:0] btn, input logic [7:0] dx,
                        input logic [7:0] dy);
      q0.push_back(8'hA5);
      q0.push_back(btn);
      q0.push_back(dx);
      q0.push_back(dy);
      q0.push_back(btn ^ dx ^ dy);
   endtask

   task automatic wait_idle(input int ch, output int len);
      int t0;
      int n;
      t0 = cyc;
      n = 0;
      while ((ch == 0 ? busy0 : busy1) && n < 5000) begin
         tick(1);
         n++;
      end
      len = cyc - t0;
      check($sformatf("idle_timeout%0d", ch),
            {31'd0, (ch == 0 ? busy0 : busy1)}, 32'd0);
   endtask

   task automatic drain(input int ch);
      int n;
      n = 0;
      while ((ch == 0 ? q0.size() : q1.size()) != 0 && n < 3000) begin
         tick(1);
         n++;
      end
      check($sformatf("drain%0d", ch),
            (ch == 0 ? q0.size() : q1.size()), 32'd0);
   endtask

   initial begin
      int len;
      int t0;
      logic [7:0] f1 [9];
      logic [7:0] x;
      logic seen;

      // reset values
      tick(3);
      check("rst_tx", {31'd0, tx0}, 32'd1);
      check("rst_busy", {31'd0, busy0}, 32'd0);
      check("rst_pending", {31'd0, pending0}, 32'd0);
      check("rst_drop", {24'd0, drop0}, 32'd0);
      rst = 1'b0;
      tick(2);

      // basic frame: dx=5, dy=-3, buttons=01
      in_valid0 = 1'b1;
      in_delta0 = {8'hFD, 8'h05};
      buttons0  = 2'b01;
      tick(1);
      in_valid0 = 1'b0;
      push0(8'h01, 8'h05, 8'hFD);
      send0 = 1'b1;
      tick(1);
      send0 = 1'b0;
      check("start_bit", {31'd0, tx0}, 32'd0);
      check("busy_rise", {31'd0, busy0}, 32'd1);
      wait_idle(0, len);
      check("busy_len", len, 32'd800);
      drain(0);

      // carry: 300 accumulated, reported as 127, 127, 46
      buttons0  = 2'b00;
      in_valid0 = 1'b1;
      in_delta0 = {8'h00, 8'd100};
      tick(3);
      in_valid0 = 1'b0;
      for (int r = 0; r < 3; r++) begin
         push0(8'h00, (r == 2) ? 8'h2E : 8'h7F, 8'h00);
         send0 = 1'b1;
         tick(1);
         send0 = 1'b0;
         wait_idle(0, len);
         tick(4);
      end
      drain(0);

      // saturation of the accumulator
      in_valid0 = 1'b1;
      in_delta0 = {8'h00, 8'h7F};
      tick(40);
      in_valid0 = 1'b0;
      check("acc_sat", int'(dut0.acc[0]), 32'd2047);
      check("acc_other", int'(dut0.acc[1]), 32'd0);
      rst = 1'b1;
      tick(2);
      rst = 1'b0;
      tick(1);
      check("acc_cleared", int'(dut0.acc[0]), 32'd0);

      // queueing: one pending, one dropped, frames back to back
      buttons0 = 2'b10;
      push0(8'h02, 8'h00, 8'h00);
      push0(8'h02, 8'h00, 8'h00);
      send0 = 1'b1;
      tick(1);
      send0 = 1'b0;
      t0 = cyc;
      tick(100);
      check("q_pend0", {31'd0, pending0}, 32'd0);
      send0 = 1'b1;
      tick(1);
      send0 = 1'b0;
      check("q_pend1", {31'd0, pending0}, 32'd1);
      check("q_drop0", {24'd0, drop0}, 32'd0);
      tick(100);
      send0 = 1'b1;
      tick(1);
      send0 = 1'b0;
      check("q_drop1", {24'd0, drop0}, 32'd1);
      check("q_pend2", {31'd0, pending0}, 32'd1);
      seen = 1'b0;
      while (busy0 && cyc - t0 < 5000) begin
         if (!seen && !pending0) begin
            seen = 1'b1;
            check("q_clear_at", cyc - t0, 32'd800);
            check("q_clear_tx", {31'd0, tx0}, 32'd0);
            check("q_clear_busy", {31'd0, busy0}, 32'd1);
         end
         tick(1);
      end
      check("q_seen", {31'd0, seen}, 32'd1);
      check("q_len", cyc - t0, 32'd1600);
      drain(0);

      // drop counter saturates
      push0(8'h02, 8'h00, 8'h00);
      push0(8'h02, 8'h00, 8'h00);
      send0 = 1'b1;
      tick(300);
      send0 = 1'b0;
      check("drop_sat", {24'd0, drop0}, 32'd255);
      check("drop_pend", {31'd0, pending0}, 32'd1);
      wait_idle(0, len);
      drain(0);

      // three 16-bit axes
      f1[0] = 8'hA5; f1[1] = 8'h00;
      f1[2] = 8'h34; f1[3] = 8'h12;
      f1[4] = 8'hFE; f1[5] = 8'hFF;
      f1[6] = 8'h00; f1[7] = 8'h00;
      x = 8'h00;
      for (int j = 1; j < 8; j++) x = x ^ f1[j];
      f1[8] = x;
      check("p_csum_model", {24'd0, x}, 32'h27);
      for (int j = 0; j < 9; j++) q1.push_back(f1[j]);
      in_valid1 = 1'b1;
      in_delta1 = {16'h0000, 16'hFFFE, 16'h1234};
      tick(1);
      in_valid1 = 1'b0;
      send1 = 1'b1;
      tick(1);
      send1 = 1'b0;
      check("p_start", {31'd0, tx1}, 32'd0);
      wait_idle(1, len);
      check("p_len", len, 32'd1440);
      drain(1);

      // reset in the middle of byte 2
      rst = 1'b1;
      tick(2);
      rst = 1'b0;
      tick(2);
      buttons0  = 2'b01;
      in_valid0 = 1'b1;
      in_delta0 = {8'h04, 8'h03};
      tick(1);
      in_valid0 = 1'b0;
      push0(8'h01, 8'h03, 8'h04);
      send0 = 1'b1;
      tick(1);
      send0 = 1'b0;
      tick(380);
      check("r_busy_pre", {31'd0, busy0}, 32'd1);
      rst = 1'b1;
      #1;
      check("r_tx", {31'd0, tx0}, 32'd1);
      check("r_busy", {31'd0, busy0}, 32'd0);
      tick(2);
      q0.delete();
      rst = 1'b0;
      tick(2);
      buttons0 = 2'b11;
      push0(8'h03, 8'h00, 8'h00);
      send0 = 1'b1;
      tick(1);
      send0 = 1'b0;
      wait_idle(0, len);
      check("r_len", len, 32'd800);
      drain(0);
      tick(20);
      check("final_q0", q0.size(), 32'd0);
      check("final_q1", q1.size(), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
